mem_arbiter: RTL and testbench

- Arbitrates the single RAM port between the datapath's instruction-fetch requester and its data-access requester.
- One request is serviced at a time.
- Data has priority over instruction, bounded by a starvation counter.
- Per-requester wait/load signals are produced from the RAM state.
- Sits between the cache/datapath side and the RAM model.

---
 rtl/mem_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between an instruction-fetch requester
// and a data-access requester, one access at a time.
//
// Data wins arbitration unless the instruction side has been passed over
// MAX_D_STREAK times in a row while waiting. A service stalled for TIMEOUT
// cycles without ACCESS is aborted (TIMEOUT=0 disables this). A RAM ERROR
// parks the block in ERRST until reset. err is sticky until RST.
//
// Ports:
//   CLK, RST                    clock (rising edge), synchronous active-high reset
//   iREN, iaddr                 instruction read request and address
//   iwait, iload                instruction wait (0 = data valid), read data
//   dREN, dWEN, daddr, dstore   data read/write request, address, write value
//   dwait, dload                data wait (0 = access done), read data
//   ramREN, ramWEN              RAM read and write enables
//   ramaddr, ramstore           RAM address and write data
//   ramload, ramstate           RAM read data; state 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
//   err                         sticky error flag
//
// Optional build macro ARB_STATS_EN adds the completion counters
// igrants[31:0] and dgrants[31:0].
module mem_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
`ifdef ARB_STATS_EN
  output logic [31:0] igrants,
  output logic [31:0] dgrants,
`endif
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DSERV = 2'd1,
    ISERV = 2'd2,
    ERRST = 2'd3
  } state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;
  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);
  localparam logic [7:0] TMO_LIM    = 8'(TIMEOUT);

  state_t      state_q, state_d, state_s;
  logic [3:0]  streak_q, streak_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        err_q, err_d;
  logic        d_req_s, tmo_hit_s, i_done_s, d_done_s;
`ifdef ARB_STATS_EN
  logic [31:0] igrants_q, igrants_d, dgrants_q, dgrants_d;
`endif

  // While RST is high the outputs must already show reset values, so decode
  // as IDLE regardless of the (possibly stale) state register.
  assign state_s   = RST ? IDLE : state_q;
  assign d_req_s   = dREN | dWEN;
  // tmo holds the number of cycles spent in the current service, including
  // the present one, so the abort lands on exactly the TIMEOUT-th cycle.
  assign tmo_hit_s = (TMO_LIM != 8'd0) && (tmo_q == TMO_LIM);

  // Next-state, counters and the combinational RAM/requester outputs.
  always_comb begin
    state_d  = state_s;
    streak_d = streak_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = 32'd0;
    dload    = 32'd0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'd0;
    ramstore = 32'd0;
    i_done_s = 1'b0;
    d_done_s = 1'b0;
    case (state_s)
      IDLE: begin
        tmo_d    = 8'd0;
        streak_d = iREN ? streak_q : 4'd0;
        if (d_req_s && !(iREN && (streak_q == STREAK_MAX))) begin
          state_d = DSERV;
          tmo_d   = 8'd1;
        end else if (iREN) begin
          state_d = ISERV;
          tmo_d   = 8'd1;
        end else begin
          state_d = IDLE;
        end
      end
      DSERV: begin
        if (!d_req_s) begin
          // Requester withdrew: release the RAM, no completion.
          state_d = IDLE;
        end else begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = ~dWEN;
          if (ramstate == RAM_ACCESS) begin
            dwait    = 1'b0;
            dload    = ramload;
            d_done_s = 1'b1;
            state_d  = IDLE;
            if (iREN) begin
              streak_d = (streak_q >= STREAK_MAX) ? STREAK_MAX : streak_q + 4'd1;
            end else begin
              streak_d = streak_q;
            end
          end else if (ramstate == RAM_ERROR) begin
            state_d = ERRST;
            err_d   = 1'b1;
          end else if (tmo_hit_s) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else begin
            tmo_d = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;
          end
        end
      end
      ISERV: begin
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ramaddr = iaddr;
          ramREN  = 1'b1;
          if (ramstate == RAM_ACCESS) begin
            iwait    = 1'b0;
            iload    = ramload;
            i_done_s = 1'b1;
            streak_d = 4'd0;
            state_d  = IDLE;
          end else if (ramstate == RAM_ERROR) begin
            state_d = ERRST;
            err_d   = 1'b1;
          end else if (tmo_hit_s) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else begin
            tmo_d = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;
          end
        end
      end
      ERRST: begin
        state_d = ERRST;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef ARB_STATS_EN
  // Completion counters wrap naturally at 2^32.
  always_comb begin
    igrants_d = i_done_s ? igrants_q + 32'd1 : igrants_q;
    dgrants_d = d_done_s ? dgrants_q + 32'd1 : dgrants_q;
  end

  assign igrants = igrants_q;
  assign dgrants = dgrants_q;
`endif

  // State and counter registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      streak_q  <= 4'd0;
      tmo_q     <= 8'd0;
      err_q     <= 1'b0;
`ifdef ARB_STATS_EN
      igrants_q <= 32'd0;
      dgrants_q <= 32'd0;
`endif
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
`ifdef ARB_STATS_EN
      igrants_q <= igrants_d;
      dgrants_q <= dgrants_d;
`endif
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  mem_arbiter #(.MAX_D_STREAK(4), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    string       exp_seq;
    logic [7:0]  seq_log [0:7];
    int          n_done, age, cnt;
    logic        err_seen;

    RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = 32'd0; daddr = 32'd0; dstore = 32'd0; ramload = 32'd0; ramstate = FREE;

    // Reset values, then 10 quiet cycles.
    cyc(); #1;
    chk("rst_flags", {59'd0, ramREN, ramWEN, iwait, dwait, err}, {59'd0, 5'b00110});
    chk("rst_ramaddr", {32'd0, ramaddr}, 64'd0);
    chk("rst_ramstore", {32'd0, ramstore}, 64'd0);
    cyc(); RST = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc(); #1;
      chk("idle_flags", {59'd0, ramREN, ramWEN, iwait, dwait, err}, {59'd0, 5'b00110});
    end

    // Single instruction read, ACCESS two cycles after the grant.
    iREN = 1'b1; iaddr = 32'h40; #1;
    chk("rd_idle_en", {63'd0, ramREN}, 64'd0);
    cyc(); ramstate = BUSY; #1;
    chk("rd_grant", {31'd0, ramREN, ramaddr}, {31'd0, 1'b1, 32'h40});
    chk("rd_wait0", {63'd0, iwait}, 64'd1);
    cyc(); #1;
    chk("rd_wait1", {63'd0, iwait}, 64'd1);
    chk("rd_iload_idle", {32'd0, iload}, 64'd0);
    cyc(); ramstate = ACCESS; ramload = 32'h8C010004; #1;
    chk("rd_done", {31'd0, iwait, iload}, {31'd0, 1'b0, 32'h8C010004});
    cyc(); iREN = 1'b0; ramstate = FREE; ramload = 32'd0; #1;
    chk("rd_after", {61'd0, ramREN, iwait, dwait}, {61'd0, 3'b011});

    // Simultaneous requests: data write first, then the instruction read.
    iREN = 1'b1; iaddr = 32'h40; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF;
    cyc(); #1;
    chk("sim_dserv", {62'd0, ramWEN, ramREN}, {62'd0, 2'b10});
    chk("sim_addr", {ramaddr, ramstore}, {32'h100, 32'hDEADBEEF});
    ramstate = ACCESS; #1;
    chk("sim_dwait", {62'd0, dwait, iwait}, {62'd0, 2'b01});
    cyc(); dWEN = 1'b0; ramstate = FREE; #1;
    chk("sim_idle", {62'd0, ramREN, ramWEN}, 64'd0);
    cyc(); #1;
    chk("sim_iserv", {30'd0, ramREN, ramWEN, ramaddr}, {30'd0, 2'b10, 32'h40});
    chk("sim_istore", {32'd0, ramstore}, 64'd0);
    ramstate = ACCESS; ramload = 32'h1234; #1;
    chk("sim_idone", {31'd0, iwait, iload}, {31'd0, 1'b0, 32'h1234});
    cyc(); iREN = 1'b0; ramstate = FREE; ramload = 32'd0;

    // Withdrawal: dREN drops mid-service, RAM released at once.
    dREN = 1'b1; daddr = 32'h180;
    cyc(); #1;
    chk("wd_grant", {62'd0, ramREN, ramWEN}, {62'd0, 2'b10});
    dREN = 1'b0; #1;
    chk("wd_release", {61'd0, ramREN, ramWEN, dwait}, {61'd0, 3'b001});
    cyc(); iREN = 1'b1; iaddr = 32'h50;
    cyc(); #1;
    chk("wd_next_iserv", {31'd0, ramREN, ramaddr}, {31'd0, 1'b1, 32'h50});
    iREN = 1'b0;
    cyc();

    // Starvation bound: 4 data completions, 1 instruction, then data again.
    exp_seq = "DDDDID";
    n_done = 0; age = 0;
    dREN = 1'b1; iREN = 1'b1; daddr = 32'h200; iaddr = 32'h80;
    for (int k = 0; k < 60 && n_done < 6; k++) begin
      cyc();
      if (ramREN | ramWEN) begin
        ramstate = (age == 1) ? ACCESS : BUSY;
        age++;
      end else begin
        ramstate = FREE;
        age = 0;
      end
      #1;
      if (!dwait) begin seq_log[n_done] = "D"; n_done++; end
      else if (!iwait) begin seq_log[n_done] = "I"; n_done++; end
    end
    dREN = 1'b0; iREN = 1'b0; ramstate = FREE;
    chk("stv_count", 64'(n_done), 64'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < n_done) chk("stv_order", {56'd0, seq_log[k]}, {56'd0, exp_seq[k]});
      else chk("stv_order", 64'd0, {56'd0, exp_seq[k]});
    end
    cyc(); cyc();

    // Timeout: BUSY forever, abort after 8 cycles in DSERV.
    dREN = 1'b1; daddr = 32'h300; ramstate = BUSY;
    cnt = 0; err_seen = 1'b0;
    cyc();
    for (int k = 0; k < 30; k++) begin
      #1;
      if (!ramREN) break;
      cnt++;
      err_seen = err_seen | err;
      cyc();
    end
    dREN = 1'b0; ramstate = FREE;
    chk("tmo_cycles", 64'(cnt), 64'd8);
    chk("tmo_err_early", {63'd0, err_seen}, 64'd0);
    chk("tmo_err_set", {63'd0, err}, 64'd1);
    iREN = 1'b1; iaddr = 32'h44;
    cyc(); ramstate = ACCESS; ramload = 32'hCAFEF00D; #1;
    chk("tmo_iserv", {31'd0, iwait, iload}, {31'd0, 1'b0, 32'hCAFEF00D});
    cyc(); iREN = 1'b0; ramstate = FREE; ramload = 32'd0; #1;
    chk("tmo_err_sticky", {63'd0, err}, 64'd1);

    // Error state: ERROR during ISERV parks the block until reset.
    RST = 1'b1; cyc(); RST = 1'b0;
    iREN = 1'b1; iaddr = 32'h48;
    cyc(); ramstate = ERROR; #1;
    chk("err_iwait", {63'd0, iwait}, 64'd1);
    cyc(); ramstate = FREE; dREN = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      chk("err_hold", {59'd0, ramREN, ramWEN, iwait, dwait, err}, {59'd0, 5'b00111});
      cyc();
    end
    RST = 1'b1; cyc(); RST = 1'b0; dREN = 1'b0; #1;
    chk("err_cleared", {60'd0, ramREN, iwait, dwait, err}, {60'd0, 4'b0110});
    cyc(); #1;
    chk("err_resume", {31'd0, ramREN, ramaddr}, {31'd0, 1'b1, 32'h48});
    iREN = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
